// File: rtl/or4_rr_arbiter_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter.
// fsm_state exposes the arbiter's IDLE/GRANT/GAP state so checkers can bind to it.
interface or4_rr_arbiter_if;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_vld;
   logic       any_req;
   logic       preempt;
   logic [1:0] fsm_state;

   // req is level-sensitive and sampled on rising clk. A grant remains valid while
   // gnt_vld=1. It ends on the first edge where req[gnt_idx]=0, or on a forced release.
   modport master (output req, input gnt, gnt_idx, gnt_vld, any_req, preempt, fsm_state);
   modport slave  (input req, output gnt, gnt_idx, gnt_vld, any_req, preempt, fsm_state);
endinterface

// File: rtl/or4_rr_arbiter.sv
// Four-way round-robin arbiter. The owner keeps its grant until it drops req.
// The optional hold limit is enabled by defining ARB_HOLD_LIMIT_EN.
module or4_rr_arbiter #(
   parameter int GAP_CYCLES = 0,
   parameter int MAX_HOLD   = 16
) (
   input  logic              clk,
   input  logic              rst,
   or4_rr_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, GAP = 2'd2} state_t;

   localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

   state_t     state, state_nxt;
   logic [3:0] gnt_q, gnt_nxt;
   logic [1:0] idx_q, idx_nxt;
   logic [1:0] last, last_nxt;
   logic [3:0] gap_cnt, gap_nxt;
   logic       preempt_q, preempt_nxt;
   logic [1:0] pick;
   logic       pick_ok;
   logic       release_now;
   logic       forced;

   // Scan from the lowest priority (last) up to last+1, so last+1 wins if set.
   always_comb begin
      pick    = 2'd0;
      pick_ok = 1'b0;
      for (int k = 4; k >= 1; k--) begin
         if (bus.req[last + 2'(k)]) begin
            pick    = last + 2'(k);
            pick_ok = 1'b1;
         end
      end
   end

   assign release_now = ~bus.req[idx_q];

`ifdef ARB_HOLD_LIMIT_EN
   localparam int HW = $clog2(MAX_HOLD + 1);
   logic [HW-1:0] hold_cnt, hold_nxt;

   always_comb begin
      hold_nxt = hold_cnt;
      if (state == IDLE && pick_ok)
         hold_nxt = '0;
      else if (state == GRANT && hold_cnt != HW'(MAX_HOLD))
         hold_nxt = hold_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) hold_cnt <= '0;
      else     hold_cnt <= hold_nxt;
   end

   assign forced = (state == GRANT) && (hold_cnt >= HW'(MAX_HOLD - 1)) && (|(bus.req & ~gnt_q));
`else
   logic unused_max_hold;
   assign unused_max_hold = (MAX_HOLD >= 2);
   assign forced = 1'b0;
`endif

   always_comb begin
      state_nxt   = state;
      gnt_nxt     = gnt_q;
      idx_nxt     = idx_q;
      last_nxt    = last;
      gap_nxt     = gap_cnt;
      preempt_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (pick_ok) begin
               gnt_nxt   = 4'b0001 << pick;
               idx_nxt   = pick;
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            if (release_now || forced) begin
               gnt_nxt     = 4'b0000;
               last_nxt    = idx_q;
               gap_nxt     = 4'd0;
               preempt_nxt = forced && !release_now;
               state_nxt   = (GAP_CYCLES > 0) ? GAP : IDLE;
            end
         end
         GAP: begin
            if (gap_cnt == GAP_LAST) state_nxt = IDLE;
            else                     gap_nxt   = gap_cnt + 4'd1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         gnt_q     <= 4'b0000;
         idx_q     <= 2'd0;
         last      <= 2'd3;
         gap_cnt   <= 4'd0;
         preempt_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         gnt_q     <= gnt_nxt;
         idx_q     <= idx_nxt;
         last      <= last_nxt;
         gap_cnt   <= gap_nxt;
         preempt_q <= preempt_nxt;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_idx   = idx_q;
   assign bus.gnt_vld   = |gnt_q;
   assign bus.any_req   = |bus.req;
   assign bus.preempt   = preempt_q;
   assign bus.fsm_state = state;

endmodule

// File: tb/tb_or4_rr_arbiter.sv
// Bench for or4_rr_arbiter: two instances (GAP_CYCLES 0 and 2) share req/rst and are
// checked every cycle against an ownership-level model; ARB_HOLD_LIMIT_EN adds hold checks.
module tb_or4_rr_arbiter;

   localparam int MAX_HOLD = 4;

   logic clk;
   logic rst;
   int   tests = 0;
   int   fails = 0;

   or4_rr_arbiter_if bus0 ();
   or4_rr_arbiter_if bus2 ();

   or4_rr_arbiter #(.GAP_CYCLES(0), .MAX_HOLD(MAX_HOLD)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
   or4_rr_arbiter #(.GAP_CYCLES(2), .MAX_HOLD(MAX_HOLD)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model per instance: current owner (-1 = none), last owner, cycles held, idle cycles left.
   int gap_of  [2] = '{0, 2};
   int m_owner [2] = '{-1, -1};
   int m_last  [2] = '{3, 3};
   int m_idx   [2] = '{0, 0};
   int m_age   [2] = '{0, 0};
   int m_wait  [2] = '{0, 0};
   bit m_pre   [2] = '{0, 0};

   task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step(int k, logic [3:0] r, bit rs);
      bit done;
      bit limit;
      int cand;
      m_pre[k] = 1'b0;
      if (rs) begin
         m_owner[k] = -1; m_last[k] = 3; m_idx[k] = 0; m_age[k] = 0; m_wait[k] = 0;
      end else if (m_owner[k] >= 0) begin
         done  = (r[m_owner[k]] == 1'b0);
         limit = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
         limit = (m_age[k] >= MAX_HOLD) && ((r & ~(4'b0001 << m_owner[k])) != 4'b0000);
`endif
         if (done || limit) begin
            m_pre[k]   = limit && !done;
            m_last[k]  = m_owner[k];
            m_owner[k] = -1;
            m_wait[k]  = gap_of[k];
         end else begin
            m_age[k]++;
         end
      end else if (m_wait[k] > 0) begin
         m_wait[k]--;
      end else if (r != 4'b0000) begin
         for (int s = 4; s >= 1; s--) begin
            cand = (m_last[k] + s) % 4;
            if (r[cand]) m_owner[k] = cand;
         end
         m_idx[k] = m_owner[k];
         m_age[k] = 1;
      end
   endtask

   task automatic chk_dut(int k, logic [3:0] g, logic [1:0] i, logic v, logic p);
      logic [3:0] eg;
      eg = (m_owner[k] >= 0) ? (4'b0001 << m_owner[k]) : 4'b0000;
      chk($sformatf("dut%0d.gnt", k * 2), {4'b0, g}, {4'b0, eg});
      chk($sformatf("dut%0d.gnt_idx", k * 2), {6'b0, i}, 8'(m_idx[k]));
      chk($sformatf("dut%0d.gnt_vld", k * 2), {7'b0, v}, {7'b0, (m_owner[k] >= 0)});
      chk($sformatf("dut%0d.preempt", k * 2), {7'b0, p}, {7'b0, m_pre[k]});
   endtask

   // Called at a negedge: drive inputs, check any_req, clock once, update model, check.
   task automatic step(logic [3:0] r, bit rs);
      bus0.req = r;
      bus2.req = r;
      rst      = rs;
      #1;
      chk("dut0.any_req", {7'b0, bus0.any_req}, {7'b0, (r != 4'b0000)});
      chk("dut2.any_req", {7'b0, bus2.any_req}, {7'b0, (r != 4'b0000)});
      @(posedge clk);
      model_step(0, r, rs);
      model_step(1, r, rs);
      @(negedge clk);
      chk_dut(0, bus0.gnt, bus0.gnt_idx, bus0.gnt_vld, bus0.preempt);
      chk_dut(1, bus2.gnt, bus2.gnt_idx, bus2.gnt_vld, bus2.preempt);
   endtask

   initial begin
      logic [3:0] r;
      bit         rs;
      int         own;
      rst      = 1'b1;
      bus0.req = 4'b0000;
      bus2.req = 4'b0000;
      @(negedge clk);

      // T1: reset with all requests high.
      step(4'b1111, 1'b1);
      step(4'b1111, 1'b1);
      chk("t1_gnt", {4'b0, bus0.gnt}, 8'h00);
      chk("t1_any_req", {7'b0, bus0.any_req}, 8'h01);

      // T2: priority after reset, then release.
      step(4'b1010, 1'b0);
      chk("t2_gnt_first", {4'b0, bus0.gnt}, 8'h02);
      chk("t2_idx_first", {6'b0, bus0.gnt_idx}, 8'h01);
      step(4'b1000, 1'b0);
      chk("t2_gnt_idle", {4'b0, bus0.gnt}, 8'h00);
      step(4'b1000, 1'b0);
      chk("t2_gnt_second", {4'b0, bus0.gnt}, 8'h08);
      chk("t2_idx_second", {6'b0, bus0.gnt_idx}, 8'h03);

      // T3: all requesting, each owner releases after 3 cycles.
      step(4'b0000, 1'b1);
      for (int n = 0; n < 5; n++) begin
         step(4'b1111, 1'b0);
         chk($sformatf("t3_order%0d", n), {4'b0, bus0.gnt}, 8'(4'b0001 << (n % 4)));
         step(4'b1111, 1'b0);
         step(4'b1111, 1'b0);
         own = m_owner[0];
         r = 4'b1111;
         if (own >= 0) r[own] = 1'b0;
         step(r, 1'b0);
         chk($sformatf("t3_gap%0d", n), {4'b0, bus0.gnt}, 8'h00);
      end

      // T4: GAP_CYCLES=2 instance, req0 releases while req2 waits.
      step(4'b0000, 1'b1);
      step(4'b0001, 1'b0);
      step(4'b0101, 1'b0);
      chk("t4_owner0", {4'b0, bus2.gnt}, 8'h01);
      for (int n = 0; n < 3; n++) begin
         step(4'b0100, 1'b0);
         chk($sformatf("t4_gap%0d", n), {4'b0, bus2.gnt}, 8'h00);
      end
      step(4'b0100, 1'b0);
      chk("t4_owner2", {4'b0, bus2.gnt}, 8'h04);

      // T5: reset mid-grant, then regrant from last=3.
      chk("t5_pre", {4'b0, bus0.gnt}, 8'h04);
      step(4'b0100, 1'b1);
      chk("t5_rst", {4'b0, bus0.gnt}, 8'h00);
      chk("t5_rst2", {4'b0, bus2.gnt}, 8'h00);
      step(4'b0100, 1'b0);
      chk("t5_regrant", {4'b0, bus0.gnt}, 8'h04);

`ifdef ARB_HOLD_LIMIT_EN
      // T6: hold limit forces a release only when someone else waits.
      step(4'b0000, 1'b1);
      step(4'b0001, 1'b0);
      chk("t6_c1", {4'b0, bus0.gnt}, 8'h01);
      for (int n = 2; n <= 4; n++) begin
         step(4'b0011, 1'b0);
         chk($sformatf("t6_c%0d", n), {4'b0, bus0.gnt}, 8'h01);
      end
      step(4'b0011, 1'b0);
      chk("t6_preempt", {7'b0, bus0.preempt}, 8'h01);
      chk("t6_released", {4'b0, bus0.gnt}, 8'h00);
      step(4'b0011, 1'b0);
      chk("t6_next", {4'b0, bus0.gnt}, 8'h02);
      chk("t6_pulse_end", {7'b0, bus0.preempt}, 8'h00);
      step(4'b0001, 1'b0);
      step(4'b0001, 1'b0);
      for (int n = 0; n < 20; n++) begin
         step(4'b0001, 1'b0);
         chk("t6_alone_gnt", {4'b0, bus0.gnt}, 8'h01);
         chk("t6_alone_pre", {7'b0, bus0.preempt}, 8'h00);
      end
`endif

      // Random phase: slowly changing request levels with occasional resets.
      r = 4'b0000;
      for (int n = 0; n < 800; n++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
         rs = ($urandom_range(0, 59) == 0);
         step(r, rs);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
